// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - ECB/CBC block-chaining sequencer in front of aes_main
// Caches the expanded key so aes_main init is only reissued on a key/keylen change.
module aes_mode_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_mode,
  input  logic             cfg_encdec,
  input  logic [255:0]     cfg_key,
  input  logic [3:0]       cfg_keylen,
  input  logic [127:0]     cfg_iv,
  input  logic [CNT_W-1:0] cfg_nblocks,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_encdec,
  output logic             core_init,
  output logic             core_next,
  output logic [255:0]     core_key,
  output logic [3:0]       core_keylen,
  output logic [127:0]     core_block,
  input  logic             core_ready,
  input  logic [127:0]     core_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_INIT, S_KEY_WAIT, S_ACCEPT, S_BLK_WAIT, S_OUTPUT, S_DONE
  } state_t;

  state_t           r_state;
  logic             r_mode, r_encdec, r_key_cached, r_skip;
  logic [255:0]     r_key;
  logic [3:0]       r_keylen;
  logic [127:0]     r_chain, r_next_chain;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done, r_in_ready, r_out_valid;
  logic             r_core_encdec, r_core_init, r_core_next;
  logic [255:0]     r_core_key;
  logic [3:0]       r_core_keylen;
  logic [127:0]     r_core_block, r_out_data;
  logic             w_key_hit;

  // core_key/core_keylen double as the cached copy; r_key_cached says it is valid
  assign w_key_hit = r_key_cached && (cfg_key == r_core_key) && (cfg_keylen == r_core_keylen);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_encdec      <= 1'b0;
      r_key_cached  <= 1'b0;
      r_skip        <= 1'b0;
      r_key         <= '0;
      r_keylen      <= '0;
      r_chain       <= '0;
      r_next_chain  <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_core_encdec <= 1'b0;
      r_core_init   <= 1'b0;
      r_core_next   <= 1'b0;
      r_core_key    <= '0;
      r_core_keylen <= '0;
      r_core_block  <= '0;
      r_out_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_mode   <= cfg_mode;
            r_encdec <= cfg_encdec;
            r_key    <= cfg_key;
            r_keylen <= cfg_keylen;
            r_chain  <= cfg_iv;
            r_cnt    <= cfg_nblocks;
            r_busy   <= 1'b1;
            if (cfg_nblocks == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_key_hit) begin
              r_in_ready <= 1'b1;
              r_state    <= S_ACCEPT;
            end else begin
              r_state <= S_KEY_INIT;
            end
          end
        end
        S_KEY_INIT: begin
          r_key_cached  <= 1'b0;
          r_core_key    <= r_key;
          r_core_keylen <= r_keylen;
          r_core_init   <= 1'b1;
          r_skip        <= 1'b1;
          r_state       <= S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          r_core_init <= 1'b0;
          // core_ready still shows the pre-pulse value during the pulse cycle
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (core_ready) begin
            r_key_cached <= 1'b1;
            r_in_ready   <= 1'b1;
            r_state      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            r_in_ready    <= 1'b0;
            r_core_block  <= (r_mode && r_encdec) ? (in_data ^ r_chain) : in_data;
            if (r_mode && !r_encdec) r_next_chain <= in_data;
            r_core_encdec <= r_encdec;
            r_core_next   <= 1'b1;
            r_skip        <= 1'b1;
            r_state       <= S_BLK_WAIT;
          end
        end
        S_BLK_WAIT: begin
          r_core_next <= 1'b0;
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (core_ready) begin
            if (r_mode && !r_encdec) begin
              r_out_data <= core_result ^ r_chain;
              r_chain    <= r_next_chain;
            end else begin
              r_out_data <= core_result;
              if (r_mode) r_chain <= core_result;
            end
            r_out_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign core_encdec = r_core_encdec;
  assign core_init   = r_core_init;
  assign core_next   = r_core_next;
  assign core_key    = r_core_key;
  assign core_keylen = r_core_keylen;
  assign core_block  = r_core_block;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb/tb_aes_mode_ctrl.sv - directed bench for aes_mode_ctrl with a table-driven aes_main stand-in
module tb_aes_mode_ctrl;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256 = {128'h603deb1015ca71be2b73aef0857d7781,
                                   128'h1f352c073b6108d72d9810a30914dff4};
  localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] X1   = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] X2   = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] E256 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start, cfg_mode, cfg_encdec;
  logic [255:0] cfg_key;
  logic [3:0]   cfg_keylen;
  logic [127:0] cfg_iv;
  logic [15:0]  cfg_nblocks;
  logic         busy, done;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         core_encdec, core_init, core_next;
  logic [255:0] core_key;
  logic [3:0]   core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;

  int checks = 0;
  int errors = 0;
  int n_init = 0, n_next = 0, n_done = 0, n_outv = 0;

  aes_mode_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_encdec(cfg_encdec),
    .cfg_key(cfg_key), .cfg_keylen(cfg_keylen), .cfg_iv(cfg_iv), .cfg_nblocks(cfg_nblocks),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_encdec(core_encdec), .core_init(core_init), .core_next(core_next),
    .core_key(core_key), .core_keylen(core_keylen), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Known-answer table standing in for aes_main; unknown inputs give a recognisable wrong value
  function automatic logic [127:0] aes_lut(input logic [255:0] k, input logic [3:0] kl,
                                           input logic enc, input logic [127:0] b);
    logic [127:0] r;
    r = ~b;
    if (k == K128 && kl == 4'd0) begin
      if (enc && b == X1) r = CT1;
      else if (enc && b == X2) r = CT2;
      else if (!enc && b == CT1) r = X1;
      else if (!enc && b == CT2) r = X2;
    end else if (k == K256 && kl == 4'd2 && enc && b == PT1) begin
      r = E256;
    end
    return r;
  endfunction

  logic [127:0] m_result = '0;
  logic         m_ready = 1'b1;
  int           m_cnt = 0;
  assign core_ready  = m_ready;
  assign core_result = m_result;

  always @(posedge clk) begin
    if (core_init) begin
      m_ready <= 1'b0;
      m_cnt   <= 4;
    end else if (core_next) begin
      m_ready  <= 1'b0;
      m_cnt    <= 3;
      m_result <= aes_lut(core_key, core_keylen, core_encdec, core_block);
    end else if (!m_ready) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (core_init) n_init <= n_init + 1;
    if (core_next) n_next <= n_next + 1;
    if (done)      n_done <= n_done + 1;
    if (out_valid) n_outv <= n_outv + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic mode, input logic enc, input logic [255:0] key,
                           input logic [3:0] kl, input logic [127:0] iv, input logic [15:0] n);
    cfg_mode = mode; cfg_encdec = enc; cfg_key = key; cfg_keylen = kl;
    cfg_iv = iv; cfg_nblocks = n; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, output logic ok);
    ok = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_block(output logic [127:0] d, output logic ok);
    ok = 1'b0;
    d = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        d = out_data;
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, in_ready, out_valid, core_init, core_next, core_encdec} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, in_ready, out_valid, core_init, core_next, core_encdec});
    end
    checks++;
    if ({out_data, core_block, core_key, core_keylen} !== '0) begin
      errors++;
      $display("FAIL reset_data: out_data=%h core_block=%h core_keylen=%h want 0",
               out_data, core_block, core_keylen);
    end
  endtask

  task automatic test_cbc_enc();
    int b_init, b_done;
    logic [127:0] r1, r2;
    logic ok1, ok2, ok3, ok4, okd;
    b_init = n_init; b_done = n_done;
    start_msg(1'b1, 1'b1, K128, 4'd0, IV, 16'd2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cbc_enc_busy: got %b want 1", busy);
    end
    cfg_iv = '1; cfg_key = K256; cfg_mode = 1'b0;
    send_block(PT1, ok1); recv_block(r1, ok2);
    send_block(PT2, ok3); recv_block(r2, ok4);
    wait_done(okd);
    tick(); tick();
    checks++;
    if (!(ok1 && ok2) || r1 !== CT1) begin
      errors++;
      $display("FAIL cbc_enc_blk1: got %h want %h (handshake ok=%b%b)", r1, CT1, ok1, ok2);
    end
    checks++;
    if (!(ok3 && ok4) || r2 !== CT2) begin
      errors++;
      $display("FAIL cbc_enc_blk2: got %h want %h (handshake ok=%b%b)", r2, CT2, ok3, ok4);
    end
    checks++;
    if (n_init - b_init !== 1) begin
      errors++;
      $display("FAIL cbc_enc_init_count: got %0d want 1", n_init - b_init);
    end
    checks++;
    if (!okd || n_done - b_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cbc_enc_done: pulses=%0d busy=%b want 1 pulse busy=0", n_done - b_done, busy);
    end
  endtask

  task automatic test_cbc_dec();
    int b_init;
    logic [127:0] r1, r2;
    logic ok1, ok2, ok3, ok4, okd;
    b_init = n_init;
    start_msg(1'b1, 1'b0, K128, 4'd0, IV, 16'd2);
    send_block(CT1, ok1); recv_block(r1, ok2);
    send_block(CT2, ok3); recv_block(r2, ok4);
    wait_done(okd);
    tick(); tick();
    checks++;
    if (!(ok1 && ok2) || r1 !== PT1) begin
      errors++;
      $display("FAIL cbc_dec_blk1: got %h want %h", r1, PT1);
    end
    checks++;
    if (!(ok3 && ok4) || r2 !== PT2) begin
      errors++;
      $display("FAIL cbc_dec_blk2: got %h want %h", r2, PT2);
    end
    checks++;
    if (!okd || n_init - b_init !== 0) begin
      errors++;
      $display("FAIL cbc_dec_cache_hit: init pulses=%0d done=%b want 0 and done", n_init - b_init, okd);
    end
  endtask

  task automatic test_ecb256();
    int b_init;
    logic [127:0] r1;
    logic ok1, ok2, okd;
    b_init = n_init;
    start_msg(1'b0, 1'b1, K256, 4'd2, IV, 16'd1);
    send_block(PT1, ok1); recv_block(r1, ok2);
    wait_done(okd);
    tick(); tick();
    checks++;
    if (!(ok1 && ok2) || r1 !== E256) begin
      errors++;
      $display("FAIL ecb256_blk: got %h want %h", r1, E256);
    end
    checks++;
    if (!okd || n_init - b_init !== 1 || core_keylen !== 4'd2) begin
      errors++;
      $display("FAIL ecb256_key_change: init pulses=%0d keylen=%0d want 1 and 2", n_init - b_init, core_keylen);
    end
  endtask

  task automatic test_backpressure();
    int b_next;
    logic [127:0] held, r1, r2;
    logic ok1, ok2, ok3, ok4, okd, seen, stable;
    start_msg(1'b0, 1'b1, K256, 4'd2, IV, 16'd2);
    send_block(PT1, ok1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    held = out_data;
    b_next = n_next;
    stable = seen;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable || n_next != b_next) begin
      errors++;
      $display("FAIL backpressure_hold: stable=%b extra_next=%0d want 1 and 0", stable, n_next - b_next);
    end
    recv_block(r1, ok2);
    send_block(PT1, ok3); recv_block(r2, ok4);
    wait_done(okd);
    tick(); tick();
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && okd) || r1 !== E256 || r2 !== E256) begin
      errors++;
      $display("FAIL backpressure_data: got %h %h want %h twice", r1, r2, E256);
    end
  endtask

  task automatic test_empty();
    int b_init, b_next, b_outv;
    logic seen;
    b_init = n_init; b_next = n_next; b_outv = n_outv;
    start_msg(1'b1, 1'b1, K128, 4'd0, IV, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tick(); tick(); tick();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL empty_done: got no done within 3 cycles want done");
    end
    checks++;
    if (n_init != b_init || n_next != b_next || n_outv != b_outv || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_quiet: init=%0d next=%0d outv=%0d busy=%b want 0 0 0 0",
               n_init - b_init, n_next - b_next, n_outv - b_outv, busy);
    end
  endtask

  task automatic test_reset_mid();
    int b_init;
    logic [127:0] r1;
    logic ok1, ok2, ok3, okd, hit;
    start_msg(1'b0, 1'b1, K256, 4'd2, IV, 16'd1);
    send_block(PT1, ok1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (core_next) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (!ok1 || !hit || {busy, done, in_ready, out_valid, core_init, core_next, core_encdec} !== 7'b0
        || {out_data, core_block, core_key, core_keylen} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ctrl=%b core_key=%h core_block=%h want all 0",
               {busy, done, in_ready, out_valid, core_init, core_next, core_encdec}, core_key, core_block);
    end
    for (int i = 0; i < 10; i++) tick();
    b_init = n_init;
    start_msg(1'b0, 1'b1, K256, 4'd2, IV, 16'd1);
    send_block(PT1, ok2); recv_block(r1, ok3);
    wait_done(okd);
    tick(); tick();
    checks++;
    if (n_init - b_init !== 1) begin
      errors++;
      $display("FAIL reset_mid_reinit: init pulses=%0d want 1", n_init - b_init);
    end
    checks++;
    if (!(ok2 && ok3 && okd) || r1 !== E256) begin
      errors++;
      $display("FAIL reset_mid_result: got %h want %h", r1, E256);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_encdec = 1'b0;
    cfg_key = '0; cfg_keylen = '0; cfg_iv = '0; cfg_nblocks = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    test_reset();
    test_cbc_enc();
    test_cbc_dec();
    test_ecb256();
    test_backpressure();
    test_empty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
